// File: rtl/lock_pkg.sv
// Shared lock definitions: state encoding, 5 MHz cycle constants,
// and the digit geometry used by both the entry and attempts blocks.
package lock_pkg;

  localparam int CLK_HZ          = 5_000_000;
  localparam int CODE_LEN_DEF    = 4;
  localparam int DIGIT_W_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 5 * CLK_HZ;
  localparam int UNLOCK_CYC_DEF  = 3 * CLK_HZ;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_BLOCKED,
    S_PROGRAM
  } state_t;

endpackage

// File: rtl/lock_cycle_timer.sv
// Cycle timer: clr restarts at 0, en counts up, done holds at LIMIT-1.
// Ports: clk5, reset (sync, active-high), clr, en -> done.
module lock_cycle_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk5,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  assign done = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk5) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/passcode_entry_ctrl.sv
// Keypad passcode sequencer: collects digits, checks on ENTER, pulses
// attempt/lock, times the unlocked window. PASSCODE_PROG_EN adds code programming.
// Ports: clk5, reset, key_valid/digit/enter/clear/prog, lockout, relock ->
//        attempt_pulse, lock_pulse, unlocked, digits_entered, prog_active.
module passcode_entry_ctrl
  import lock_pkg::*;
#(
  parameter int CODE_LEN    = CODE_LEN_DEF,
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int UNLOCK_CYC  = UNLOCK_CYC_DEF
) (
  input  logic                            clk5,
  input  logic                            reset,
  input  logic                            key_valid,
  input  logic [DIGIT_W-1:0]              key_digit,
  input  logic                            key_enter,
  input  logic                            key_clear,
  input  logic                            key_prog,
  input  logic                            lockout,
  input  logic                            relock,
  output logic                            attempt_pulse,
  output logic                            lock_pulse,
  output logic                            unlocked,
  output logic [$clog2(CODE_LEN+2)-1:0]   digits_entered,
  output logic                            prog_active
);

  localparam int BW = CODE_LEN * DIGIT_W;
  localparam int CW = $clog2(CODE_LEN + 2);
  localparam logic [CW-1:0] FULL = CW'(CODE_LEN);
  localparam logic [CW-1:0] OVER = CW'(CODE_LEN + 1);

  state_t        state_q, state_n;
  logic [BW-1:0] buf_q, buf_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          ovf_q, ovf_n;
  logic [BW-1:0] code;
  logic          match;
  logic          take;
  logic          key_hit;
  logic          to_clr, to_done;
  logic          ut_clr, ut_done;

  function automatic logic [BW-1:0] put(
    input logic [BW-1:0]      b,
    input logic [CW-1:0]      idx,
    input logic [DIGIT_W-1:0] d
  );
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx == CW'(i)) begin
        r[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = d;
      end
    end
    return r;
  endfunction

  assign match = (cnt_q == FULL) && !ovf_q && (buf_q == code);

`ifdef PASSCODE_PROG_EN
  logic commit;

  always_ff @(posedge clk5) begin
    if (reset) begin
      code <= DEFAULT_CODE;
    end else if (commit) begin
      code <= buf_q;
    end
  end
`else
  logic prog_unused;

  assign prog_unused = key_prog;
  assign code        = DEFAULT_CODE;
`endif

  always_comb begin
    state_n = state_q;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    ovf_n   = ovf_q;
    take    = 1'b0;
    key_hit = 1'b0;
    ut_clr  = 1'b0;
`ifdef PASSCODE_PROG_EN
    commit  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (lockout) begin
          state_n = S_BLOCKED;
        end else if (key_valid && !key_clear && !key_enter) begin
          take    = 1'b1;
          state_n = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (lockout) begin
          state_n = S_BLOCKED;
        end else if (key_clear) begin
          state_n = S_IDLE;
        end else if (key_enter) begin
          state_n = S_CHECK;
        end else if (key_valid) begin
          take    = 1'b1;
          key_hit = 1'b1;
        end else if (to_done) begin
          state_n = S_IDLE;
        end
      end
      S_CHECK: begin
        ut_clr  = match;
        state_n = match ? S_UNLOCKED : S_IDLE;
      end
      S_UNLOCKED: begin
        if (relock || ut_done) begin
          state_n = S_IDLE;
`ifdef PASSCODE_PROG_EN
        end else if (key_prog) begin
          state_n = S_PROGRAM;
`endif
        end
      end
      S_BLOCKED: begin
        if (!lockout) begin
          state_n = S_IDLE;
        end
      end
`ifdef PASSCODE_PROG_EN
      S_PROGRAM: begin
        if (key_clear) begin
          state_n = S_UNLOCKED;
        end else if (key_enter) begin
          commit  = (cnt_q == FULL) && !ovf_q;
          ut_clr  = commit;
          state_n = S_UNLOCKED;
        end else if (key_valid) begin
          take    = 1'b1;
          key_hit = 1'b1;
        end else if (to_done) begin
          state_n = S_UNLOCKED;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    // Extra digits mark overflow without disturbing the buffer.
    if (take) begin
      if (cnt_q < FULL) begin
        buf_n = put(buf_q, cnt_q, key_digit);
        cnt_n = cnt_q + 1'b1;
      end else begin
        ovf_n = 1'b1;
        cnt_n = OVER;
      end
    end

    if (state_n != S_ENTRY && state_n != S_PROGRAM && state_n != S_CHECK) begin
      buf_n = '0;
      cnt_n = '0;
      ovf_n = 1'b0;
    end
  end

  assign to_clr = key_hit || (state_n != state_q);

  lock_cycle_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_key_timer (
    .clk5  (clk5),
    .reset (reset),
    .clr   (to_clr),
    .en    (state_q == S_ENTRY || state_q == S_PROGRAM),
    .done  (to_done)
  );

  lock_cycle_timer #(
    .LIMIT (UNLOCK_CYC)
  ) u_unlock_timer (
    .clk5  (clk5),
    .reset (reset),
    .clr   (ut_clr),
    .en    (state_q == S_UNLOCKED),
    .done  (ut_done)
  );

  always_ff @(posedge clk5) begin
    if (reset) begin
      state_q        <= S_IDLE;
      buf_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      attempt_pulse  <= 1'b0;
      lock_pulse     <= 1'b0;
      unlocked       <= 1'b0;
      digits_entered <= '0;
      prog_active    <= 1'b0;
    end else begin
      state_q        <= state_n;
      buf_q          <= buf_n;
      cnt_q          <= cnt_n;
      ovf_q          <= ovf_n;
      attempt_pulse  <= (state_q == S_CHECK) && !match;
      lock_pulse     <= (state_q == S_CHECK) && match;
      unlocked       <= (state_n == S_UNLOCKED) || (state_n == S_PROGRAM);
      digits_entered <= (state_n == S_ENTRY || state_n == S_PROGRAM) ? cnt_n : '0;
      prog_active    <= (state_n == S_PROGRAM);
    end
  end

endmodule

// File: tb/tb_passcode_entry_ctrl.sv
// Directed bench for passcode_entry_ctrl with short timeout/unlock windows.
// Table of code entries plus hand sequences for timeout, clear, lockout, relock.
module tb_passcode_entry_ctrl;

  logic       clk5 = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       key_prog = 1'b0;
  logic       lockout = 1'b0;
  logic       relock = 1'b0;
  logic       attempt_pulse;
  logic       lock_pulse;
  logic       unlocked;
  logic [2:0] digits_entered;
  logic       prog_active;

  int total = 0;
  int bad = 0;
  int n_att = 0;
  int n_lock = 0;

  always #5 clk5 = ~clk5;

  passcode_entry_ctrl #(
    .CODE_LEN     (4),
    .DIGIT_W      (4),
    .DEFAULT_CODE (16'h1234),
    .TIMEOUT_CYC  (20),
    .UNLOCK_CYC   (10)
  ) dut (
    .clk5           (clk5),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_digit      (key_digit),
    .key_enter      (key_enter),
    .key_clear      (key_clear),
    .key_prog       (key_prog),
    .lockout        (lockout),
    .relock         (relock),
    .attempt_pulse  (attempt_pulse),
    .lock_pulse     (lock_pulse),
    .unlocked       (unlocked),
    .digits_entered (digits_entered),
    .prog_active    (prog_active)
  );

  always @(negedge clk5) begin
    if (attempt_pulse) n_att++;
    if (lock_pulse) n_lock++;
  end

  typedef struct {
    logic [23:0] dg;
    int          n;
    int          de;
    bit          ok;
    int          unl;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk5);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
    key_digit = '0;
  endtask

  task automatic enter_code(input logic [23:0] dg, input int n);
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      d = dg[23-4*i -: 4];
      press(d);
    end
  endtask

  task automatic hit_enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  // Leaves the bench in the pulse cycle (N+2).
  task automatic try_code(input string nm, input logic [23:0] dg, input bit ok);
    enter_code(dg, 4);
    hit_enter();
    tick();
    chk({nm, "_lock"}, lock_pulse, ok);
    chk({nm, "_att"}, attempt_pulse, !ok);
  endtask

  vec_t tbl[7];
  int   hi;
  int   a0;
  int   l0;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{24'h123400, 4, 4, 1'b1, 10};
    tbl[1] = '{24'h123500, 4, 4, 1'b0, 0};
    tbl[2] = '{24'h123000, 3, 3, 1'b0, 0};
    tbl[3] = '{24'h123440, 5, 5, 1'b0, 0};
    tbl[4] = '{24'h123444, 6, 5, 1'b0, 0};
    tbl[5] = '{24'h432100, 4, 4, 1'b0, 0};
    tbl[6] = '{24'h123400, 4, 4, 1'b1, 10};

    tick();
    tick();
    chk("rst_att", attempt_pulse, 0);
    chk("rst_lock", lock_pulse, 0);
    chk("rst_unl", unlocked, 0);
    chk("rst_de", digits_entered, 0);
    chk("rst_prog", prog_active, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      a0 = n_att;
      l0 = n_lock;
      enter_code(tbl[v].dg, tbl[v].n);
      chk("de_before", digits_entered, tbl[v].de);
      hit_enter();
      chk("chk_cyc_pulses", {attempt_pulse, lock_pulse}, 0);
      chk("chk_cyc_de", digits_entered, 0);
      tick();
      chk("vec_lock", lock_pulse, tbl[v].ok);
      chk("vec_att", attempt_pulse, !tbl[v].ok);
      hi = unlocked ? 1 : 0;
      tick();
      chk("pulse_off", {attempt_pulse, lock_pulse}, 0);
      for (int c = 0; c < 30; c++) begin
        if (!unlocked) break;
        hi++;
        tick();
      end
      chk("unl_cycles", hi, tbl[v].unl);
      chk("de_after", digits_entered, 0);
      chk("pulse_count", (n_att - a0) + (n_lock - l0), 1);
    end

    a0 = n_att;
    l0 = n_lock;
    hit_enter();
    tick();
    tick();
    chk("idle_enter", (n_att - a0) + (n_lock - l0), 0);

    enter_code(24'h120000, 2);
    for (int c = 0; c < 19; c++) tick();
    chk("timeout_edge_de", digits_entered, 2);
    tick();
    chk("timeout_de", digits_entered, 0);
    tick();
    chk("timeout_nopulse", (n_att - a0) + (n_lock - l0), 0);

    enter_code(24'h123400, 4);
    key_clear = 1'b1;
    key_enter = 1'b1;
    tick();
    key_clear = 1'b0;
    key_enter = 1'b0;
    chk("clear_wins_de", digits_entered, 0);
    tick();
    tick();
    chk("clear_wins_nopulse", (n_att - a0) + (n_lock - l0), 0);
    chk("clear_wins_unl", unlocked, 0);

    enter_code(24'h120000, 2);
    lockout = 1'b1;
    tick();
    chk("blk_de", digits_entered, 0);
    enter_code(24'h123400, 4);
    hit_enter();
    tick();
    tick();
    chk("blk_de2", digits_entered, 0);
    chk("blk_unl", unlocked, 0);
    chk("blk_nopulse", (n_att - a0) + (n_lock - l0), 0);
    lockout = 1'b0;
    tick();
    try_code("after_blk", 24'h123400, 1'b1);
    chk("after_blk_unl", unlocked, 1);

    tick();
    press(4'h5);
    chk("unl_digit_ign", digits_entered, 0);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk("relock", unlocked, 0);

    try_code("lk_unl", 24'h123400, 1'b1);
    lockout = 1'b1;
    tick();
    tick();
    tick();
    chk("lockout_ign_unl", unlocked, 1);
    lockout = 1'b0;
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk("relock2", unlocked, 0);

    enter_code(24'h123500, 4);
    hit_enter();
    lockout = 1'b1;
    tick();
    chk("lk_check_att", attempt_pulse, 1);
    tick();
    lockout = 1'b0;
    tick();
    tick();

`ifdef PASSCODE_PROG_EN
    try_code("pg_open", 24'h123400, 1'b1);
    key_prog = 1'b1;
    tick();
    key_prog = 1'b0;
    chk("pg_active", prog_active, 1);
    enter_code(24'h987600, 4);
    chk("pg_de", digits_entered, 4);
    hit_enter();
    chk("pg_done", prog_active, 0);
    chk("pg_unl", unlocked, 1);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    try_code("pg_old", 24'h123400, 1'b0);
    tick();
    try_code("pg_new", 24'h987600, 1'b1);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    try_code("pg_rst", 24'h123400, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
